// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types, symbol constants and counter sizing for the Morse key front end
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        COMMIT,
        HOLD
    } state_t;

    localparam int MAX_SYM = 5;
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // One spare bit above the largest count so saturation never aliases a threshold.
    function automatic int cnt_width(input int unsigned max_cyc);
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stable-count debouncer and edge pulses for the key
module key_debounce
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic rise,
    output logic fall
);

    localparam int W = cnt_width(DEBOUNCE_CYC);

    logic         sync1;
    logic         sync2;
    logic         level;
    logic [W-1:0] stable_cnt;

    // Pulses are registered together with the level change so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt >= W'(DEBOUNCE_CYC - 1)) begin
                level      <= sync2;
                rise       <= sync2;
                fall       <= ~sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/morse_key_ctrl.sv
// rtl/morse_key_ctrl.sv - key timing, symbol accumulation and letter commit sequencer
// Optional word-space emission after a long idle period: MORSE_WORD_GAP_EN.
module morse_key_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned DASH_CYC     = 30000000,
    parameter int unsigned GAP_CYC      = 60000000,
    parameter int unsigned HOLD_CYC     = 1100000,
    parameter int unsigned WORD_CYC     = 150000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic [4:0] led_morse,
    output logic [2:0] led_cnt,
    output logic       trans,
    output logic       busy,
    output logic       err
);

    localparam int unsigned MAX_A   = (DASH_CYC > GAP_CYC) ? DASH_CYC : GAP_CYC;
    localparam int unsigned MAX_B   = (HOLD_CYC > WORD_CYC) ? HOLD_CYC : WORD_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          W       = cnt_width(MAX_CYC);

    logic         key_rise;
    logic         key_fall;
    state_t       state;
    logic [W-1:0] press_cnt;
    logic [W-1:0] gap_cnt;
    logic [W-1:0] hold_cnt;
    logic         ovf;
    logic         sym;
`ifdef MORSE_WORD_GAP_EN
    logic [W-1:0] idle_cnt;
    logic         word_armed;
`endif

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .rise (key_rise),
        .fall (key_fall)
    );

    // press_cnt lags the true press length by one on the release cycle.
    assign sym = (press_cnt >= W'(DASH_CYC - 1)) ? SYM_DASH : SYM_DOT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            led_morse <= '0;
            led_cnt   <= '0;
            trans     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            press_cnt <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
`ifdef MORSE_WORD_GAP_EN
            idle_cnt   <= '0;
            word_armed <= 1'b0;
`endif
        end else begin
            trans <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_rise) begin
                        state     <= PRESS;
                        busy      <= 1'b1;
                        press_cnt <= '0;
`ifdef MORSE_WORD_GAP_EN
                        word_armed <= 1'b0;
                    end else if (word_armed && idle_cnt == W'(WORD_CYC - 1)) begin
                        state      <= COMMIT;
                        busy       <= 1'b1;
                        trans      <= 1'b1;
                        err        <= 1'b0;
                        led_morse  <= '0;
                        led_cnt    <= '0;
                        word_armed <= 1'b0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + W'(1);
`endif
                    end
                end
                PRESS: begin
                    if (press_cnt != '1) press_cnt <= press_cnt + W'(1);
                    if (key_fall) begin
                        if (led_cnt < 3'(MAX_SYM)) begin
                            led_morse <= {led_morse[3:0], sym};
                            led_cnt   <= led_cnt + 3'd1;
                        end else begin
                            err <= 1'b1;
                            ovf <= 1'b1;
                        end
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt != '1) gap_cnt <= gap_cnt + W'(1);
                    // A press arriving on the expiry cycle keeps the letter open.
                    if (key_rise) begin
                        state     <= PRESS;
                        press_cnt <= '0;
                    end else if (gap_cnt == W'(GAP_CYC - 1)) begin
                        if (ovf) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            ovf       <= 1'b0;
                            led_morse <= '0;
                            led_cnt   <= '0;
`ifdef MORSE_WORD_GAP_EN
                            idle_cnt <= '0;
`endif
                        end else begin
                            state <= COMMIT;
                            trans <= 1'b1;
                            err   <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
                            word_armed <= 1'b1;
`endif
                        end
                    end
                end
                COMMIT: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: begin
                    if (hold_cnt == W'(HOLD_CYC - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        led_morse <= '0;
                        led_cnt   <= '0;
`ifdef MORSE_WORD_GAP_EN
                        idle_cnt <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_ctrl.sv
// tb/tb_morse_key_ctrl.sv - directed self-checking bench for morse_key_ctrl
module tb_morse_key_ctrl;

    localparam int DEB  = 4;
    localparam int GAP  = 40;
    localparam int HOLD = 10;
    // Raw key release to trans: 2 sync flops, DEB stable cycles, then GAP+1.
    localparam int LAT  = 2 + DEB + GAP + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key = 1'b0;
    logic [4:0] led_morse;
    logic [2:0] led_cnt;
    logic       trans;
    logic       busy;
    logic       err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int trans_cnt = 0;
    int rel_cyc = 0;

    morse_key_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .DASH_CYC    (20),
        .GAP_CYC     (GAP),
        .HOLD_CYC    (HOLD),
        .WORD_CYC    (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .led_morse(led_morse),
        .led_cnt  (led_cnt),
        .trans    (trans),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (trans) trans_cnt <= trans_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int n);
        key = 1'b1;
        tick(n);
        key = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_trans(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 250 && !seen; i++) begin
            tick(1);
            if (trans) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic commit_check(input string tag, input logic [4:0] exp_m, input logic [2:0] exp_c);
        int base;
        base = trans_cnt;
        wait_trans(tag);
        check({tag, "_lat"}, cyc - rel_cyc, LAT);
        check({tag, "_morse"}, led_morse, exp_m);
        check({tag, "_cnt"}, led_cnt, exp_c);
        check({tag, "_err"}, err, 0);
        tick(1);
        check({tag, "_trans_1cyc"}, trans, 0);
        tick(HOLD - 1);
        check({tag, "_hold_morse"}, led_morse, exp_m);
        check({tag, "_hold_cnt"}, led_cnt, exp_c);
        check({tag, "_hold_busy"}, busy, 1);
        tick(1);
        check({tag, "_clr_morse"}, led_morse, 0);
        check({tag, "_clr_cnt"}, led_cnt, 0);
        check({tag, "_clr_busy"}, busy, 0);
        check({tag, "_ntrans"}, trans_cnt, base + 1);
    endtask

    initial begin
        int base;
        bit any_busy;

        tick(3);
        check("rst_morse", led_morse, 0);
        check("rst_cnt", led_cnt, 0);
        check("rst_trans", trans, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick(5);

        // 'A': dot then dash
        press(8);
        tick(5);
        check("a_busy_gap", busy, 1);
        tick(5);
        press(30);
        commit_check("a", 5'b00001, 3'd2);

        // 'T': single dash
        press(25);
        commit_check("t", 5'b00001, 3'd1);

        // 19 cycles is a dot, 20 a dash; a 40-cycle release stays in the letter
        press(19);
        tick(40);
        press(20);
        commit_check("bound", 5'b00001, 3'd2);

        // Six dots overflow the pattern
        base = trans_cnt;
        for (int i = 0; i < 6; i++) begin
            press(6);
            if (i < 5) tick(10);
        end
        tick(60);
        check("ovf_err", err, 1);
        check("ovf_morse", led_morse, 0);
        check("ovf_cnt", led_cnt, 0);
        check("ovf_busy", busy, 0);
        check("ovf_ntrans", trans_cnt, base);
        press(6);
        commit_check("ovf_next", 5'b00000, 3'd1);

        // Short glitches never get past the debouncer
        base = trans_cnt;
        any_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key = 1'b1;
            tick(2);
            key = 1'b0;
            for (int j = 0; j < 12; j++) begin
                tick(1);
                if (busy) any_busy = 1'b1;
            end
        end
        check("glitch_busy", any_busy, 0);
        check("glitch_ntrans", trans_cnt, base);

        // Key held through HOLD is not a new press
        base = trans_cnt;
        press(6);
        wait_trans("heldk");
        key = 1'b1;
        tick(20);
        check("heldk_busy_on", busy, 0);
        tick(10);
        key = 1'b0;
        tick(45);
        check("heldk_busy_off", busy, 0);
        check("heldk_ntrans", trans_cnt, base + 1);

        // Reset during HOLD discards everything
        base = trans_cnt;
        press(8);
        tick(10);
        press(30);
        wait_trans("rsth");
        tick(3);
        rst_n = 1'b0;
        #1;
        check("rsth_morse", led_morse, 0);
        check("rsth_cnt", led_cnt, 0);
        check("rsth_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(80);
        check("rsth_ntrans", trans_cnt, base + 1);

        // 'E' followed by a long idle
        base = trans_cnt;
        press(6);
        commit_check("e", 5'b00000, 3'd1);
`ifdef MORSE_WORD_GAP_EN
        wait_trans("space");
        check("space_morse", led_morse, 0);
        check("space_cnt", led_cnt, 0);
        tick(300);
        check("space_ntrans", trans_cnt, base + 2);
`else
        tick(300);
        check("idle_ntrans", trans_cnt, base + 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
